// File: rtl/apb_master.sv
// apb_master: turns valid/ready user requests into APB transfers (one outstanding), with a wait-state timeout
module apb_master #(
  parameter int size    = 32,
  parameter int addr    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk_APB,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [addr-1:0] req_addr,
  input  logic [size-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [size-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            PSEL,
  output logic            PEN,
  output logic            PW,
  output logic [addr-1:0] PADDR,
  output logic [size-1:0] PWDATA,
  input  logic [size-1:0] PRDATA,
  input  logic            PREADY
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t          state_q;
  logic            psel_q, pen_q, pw_q, rsp_valid_q, rsp_err_q;
  logic [addr-1:0] paddr_q;
  logic [size-1:0] pwdata_q, rsp_rdata_q;
  logic [7:0]      wait_q, wait_d;
  logic            accept, done, abort;
  assign done      = state_q == ACCESS && PREADY;
  assign abort     = state_q == ACCESS && !PREADY && wait_q == LAST;
  assign req_ready = state_q == IDLE || done;
  assign accept    = req_valid && req_ready;
  assign wait_d    = accept ? 8'd0 : (state_q == ACCESS && !PREADY) ? wait_q + 8'd1 : wait_q;
  assign PSEL      = psel_q;
  assign PEN       = pen_q;
  assign PW        = pw_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  // FSM with registered APB and response outputs; PSEL/PEN encode the next state
  always_ff @(posedge clk_APB or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      pen_q       <= 1'b0;
      pw_q        <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_q      <= 8'd0;
    end else begin
      wait_q      <= wait_d;
      rsp_valid_q <= done || abort;
      if (done || abort) begin
        rsp_err_q   <= abort;
        rsp_rdata_q <= done && !pw_q ? PRDATA : '0;
      end
      if (accept) begin
        pw_q     <= req_write;
        paddr_q  <= req_addr;
        pwdata_q <= req_wdata;
      end
      psel_q  <= accept || state_q == SETUP || (state_q == ACCESS && !done && !abort);
      pen_q   <= state_q == SETUP || (state_q == ACCESS && !done && !abort);
      state_q <= accept ? SETUP : state_q == SETUP ? ACCESS : (done || abort) ? IDLE : state_q;
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized bench checking apb_master against a per-cycle transfer schedule model
module tb_apb_master;
  localparam int TO = 4, NC = 4096;
  logic clk = 0, rst = 1, req_valid = 0, req_write = 0, PREADY = 0;
  logic [7:0] req_addr = 0;
  logic [31:0] req_wdata = 0, PRDATA = 0;
  logic req_ready, rsp_valid, rsp_err, PSEL, PEN, PW;
  logic [7:0] PADDR;
  logic [31:0] PWDATA, rsp_rdata;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit busy[NC], last[NC], e_pen[NC], e_pready[NC], e_rv[NC], e_err[NC], e_pw[NC], rst_at[NC];
  logic [7:0] e_addr[NC];
  logic [31:0] e_wd[NC], e_prd[NC], e_rd[NC];
  logic [31:0] held_rd = 0;
  bit held_err = 0;

  apb_master #(.size(32), .addr(8), .TIMEOUT(TO)) dut (
    .clk_APB(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PEN(PEN), .PW(PW), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endfunction

  // A transfer accepted at cycle c: one SETUP cycle, then min(waits+1, TO) ACCESS cycles, then the response.
  task automatic sched(input bit w, input logic [7:0] a, input logic [31:0] d, input int waits,
                       input logic [31:0] rd, input int c);
    int ac;
    ac = waits < TO ? waits + 1 : TO;
    for (int i = c + 1; i < c + 2 + ac; i++) begin
      busy[i] = 1; e_pen[i] = i > c + 1; e_pw[i] = w; e_addr[i] = a; e_wd[i] = d; e_prd[i] = $urandom;
    end
    if (waits < TO) begin
      e_pready[c + 2 + waits] = 1; last[c + 2 + waits] = 1; e_prd[c + 2 + waits] = rd;
    end
    e_rv[c + 2 + ac] = 1;
    e_err[c + 2 + ac] = waits >= TO;
    e_rd[c + 2 + ac] = (waits >= TO || w) ? 32'h0 : rd;
  endtask

  task automatic step(input bit v, input bit w, input logic [7:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rd, output bit acc);
    @(posedge clk); #1;
    cyc++;
    rst = 0;
    PREADY = e_pready[cyc];
    PRDATA = busy[cyc] ? e_prd[cyc] : $urandom;
    req_valid = v;
    req_write = v ? w : 1'($urandom);
    req_addr = v ? a : 8'($urandom);
    req_wdata = v ? d : $urandom;
    acc = v && (!busy[cyc] || last[cyc]);
    if (acc) sched(w, a, d, waits, rd, cyc);
  endtask

  task automatic idle(input int n);
    bit x;
    repeat (n) step(0, 0, 0, 0, 0, 0, x);
  endtask

  task automatic issue(input bit w, input logic [7:0] a, input logic [31:0] d, input int waits,
                       input logic [31:0] rd, output int ac_cyc);
    bit acc;
    int n;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      step(1, w, a, d, waits, rd, acc);
      n++;
    end
    chk("accepted", 32'(acc), 1);
    ac_cyc = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    rst = 1; req_valid = 0; PREADY = 0;
    for (int i = cyc; i < NC; i++) begin
      busy[i] = 0; last[i] = 0; e_pen[i] = 0; e_pready[i] = 0; e_rv[i] = 0;
    end
    rst_at[cyc] = 1;
  endtask

  // compare DUT outputs against the schedule every cycle, mid-cycle
  always @(negedge clk) if (cyc > 0 && cyc < NC) begin
    if (rst_at[cyc]) begin
      held_rd = 0; held_err = 0;
      chk("rst_PW", PW, 0); chk("rst_PADDR", PADDR, 0); chk("rst_PWDATA", PWDATA, 0);
    end
    if (e_rv[cyc]) begin
      held_rd = e_rd[cyc]; held_err = e_err[cyc];
    end
    chk("req_ready", req_ready, 32'(!busy[cyc] || last[cyc]));
    chk("PSEL", PSEL, busy[cyc]);
    chk("PEN", PEN, e_pen[cyc]);
    chk("rsp_valid", rsp_valid, e_rv[cyc]);
    chk("rsp_err", rsp_err, held_err);
    chk("rsp_rdata", rsp_rdata, held_rd);
    if (busy[cyc]) begin
      chk("PW", PW, e_pw[cyc]); chk("PADDR", PADDR, e_addr[cyc]); chk("PWDATA", PWDATA, e_wd[cyc]);
    end
  end

  initial begin
    int a, a2, pen_cnt;
    bit x;
    #3;
    chk("reset_PSEL", PSEL, 0); chk("reset_PEN", PEN, 0); chk("reset_PW", PW, 0);
    chk("reset_PADDR", PADDR, 0); chk("reset_PWDATA", PWDATA, 0); chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0); chk("reset_rsp_rdata", rsp_rdata, 0);
    idle(2);
    issue(1, 8'h01, 32'h0000_00A5, 0, 0, a);
    idle(3);
    chk("wr_rsp_valid", rsp_valid, 1); chk("wr_rsp_err", rsp_err, 0); chk("wr_rsp_rdata", rsp_rdata, 0);
    issue(0, 8'h04, $urandom, 2, 32'hBABA_BAB4, a);
    pen_cnt = 0;
    repeat (5) begin
      step(0, 0, 0, 0, 0, 0, x);
      pen_cnt += int'(PEN);
    end
    chk("rd_pen_cycles", pen_cnt, 3); chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hBABA_BAB4); chk("rd_rsp_err", rsp_err, 0);
    issue(1, 8'h02, $urandom, 0, 0, a);
    issue(0, 8'h05, 0, 0, $urandom, a2);
    chk("b2b_spacing", a2 - a, 2);
    idle(4);
    issue(0, 8'h10, 0, TO + 5, $urandom, a);
    pen_cnt = 0;
    repeat (6) begin
      step(0, 0, 0, 0, 0, 0, x);
      pen_cnt += int'(PEN);
    end
    chk("to_pen_cycles", pen_cnt, TO); chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1); chk("to_rsp_rdata", rsp_rdata, 0); chk("to_PSEL", PSEL, 0);
    issue(0, 8'h20, 0, 3, $urandom, a);
    idle(2);
    do_reset();
    #1;
    chk("midrst_PSEL", PSEL, 0); chk("midrst_PEN", PEN, 0);
    idle(6);
    issue(0, 8'h21, 0, 1, 32'h1234_5678, a);
    idle(4);
    chk("postrst_rsp_valid", rsp_valid, 1); chk("postrst_rsp_rdata", rsp_rdata, 32'h1234_5678);
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      issue(1'($urandom), 8'($urandom), $urandom, (k % 25 == 24) ? TO + 1 : int'($urandom_range(0, 3)), $urandom, a);
    end
    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
